// File: rtl/tdm_output.sv
// tdm_output: two-channel TDM transmitter with a 256-count frame counter and a one-deep input holding register
module tdm_output #(
  parameter bit UNDERRUN_ZERO = 1'b0
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [15:0] ch1_in,
  input  logic [15:0] ch2_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  cnt256_n,
  output logic        bclk,
  output logic        fs,
  output logic        tdm_out,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);
  logic [7:0]  cnt;
  logic        full;
  logic [15:0] hold1, hold2, last1, last2;
  logic [63:0] sr;
  logic        load, shift, accept;
  assign load     = cnt == 8'd255;
  assign shift    = cnt[1:0] == 2'd3 && !load;
  assign accept   = in_valid && !full;
  assign in_ready = !full;
  assign cnt256_n = cnt;
  assign bclk     = cnt[1];
  assign fs       = cnt[7:2] == 6'd0;
  assign tdm_out  = sr[63];
  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt          <= 8'd0;
      full         <= 1'b0;
      hold1        <= 16'd0;
      hold2        <= 16'd0;
      last1        <= 16'd0;
      last2        <= 16'd0;
      sr           <= 64'd0;
      underrun     <= 1'b0;
      underrun_cnt <= 16'd0;
    end else begin
      cnt  <= cnt + 8'd1;
      full <= load ? accept : (full || accept);
      if (accept) begin
        hold1 <= ch1_in;
        hold2 <= ch2_in;
      end
      if (load && full) begin
        sr    <= {hold1, 16'h0000, hold2, 16'h0000};
        last1 <= hold1;
        last2 <= hold2;
      end else if (load) begin
        // underrun: a pair accepted on this same edge waits for the next frame
        sr       <= UNDERRUN_ZERO ? 64'd0 : {last1, 16'h0000, last2, 16'h0000};
        underrun <= 1'b1;
        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end else if (shift) begin
        sr <= {sr[62:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_tdm_output.sv
// tb_tdm_output: frame-level reference model feeding a scoreboard, checked against two DUTs (repeat and zero underrun policies)
module tb_tdm_output;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ch1 = 16'd0, ch2 = 16'd0;
  logic        in_valid = 1'b0;
  logic [1:0]  rdy, bclk_o, fs_o, tdm_o, ur_o;
  logic [7:0]  cnt_o [2];
  logic [15:0] urc_o [2];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  tdm_output #(.UNDERRUN_ZERO(1'b0)) dut0 (
    .mclk(clk), .rst(rst), .ch1_in(ch1), .ch2_in(ch2), .in_valid(in_valid),
    .in_ready(rdy[0]), .cnt256_n(cnt_o[0]), .bclk(bclk_o[0]), .fs(fs_o[0]),
    .tdm_out(tdm_o[0]), .underrun(ur_o[0]), .underrun_cnt(urc_o[0]));
  tdm_output #(.UNDERRUN_ZERO(1'b1)) dut1 (
    .mclk(clk), .rst(rst), .ch1_in(ch1), .ch2_in(ch2), .in_valid(in_valid),
    .in_ready(rdy[1]), .cnt256_n(cnt_o[1]), .bclk(bclk_o[1]), .fs(fs_o[1]),
    .tdm_out(tdm_o[1]), .underrun(ur_o[1]), .underrun_cnt(urc_o[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one expected 64-bit frame word per load, per underrun policy
  logic [7:0]  mcnt = 8'd0;
  logic        mfull = 1'b0, mu = 1'b0, mrst = 1'b1, macc = 1'b0;
  logic [15:0] h1 = 16'd0, h2 = 16'd0, l1 = 16'd0, l2 = 16'd0;
  int          mur = 0;
  logic [63:0] q0 [$], q1 [$];

  always @(posedge clk) begin
    logic was_full;
    if (rst) begin
      mcnt = 8'd0; mfull = 1'b0; mu = 1'b0; mur = 0; mrst = 1'b1; macc = 1'b0;
      l1 = 16'd0; l2 = 16'd0;
      q0.delete(); q1.delete();
      q0.push_back(64'd0); q1.push_back(64'd0);
    end else begin
      mrst = 1'b0;
      was_full = mfull;
      macc = in_valid && !mfull;
      if (mcnt == 8'd255) begin
        if (was_full) begin
          l1 = h1; l2 = h2;
        end else begin
          mu = 1'b1;
          if (mur < 65535) mur++;
        end
        q0.push_back({l1, 16'h0000, l2, 16'h0000});
        q1.push_back(was_full ? {l1, 16'h0000, l2, 16'h0000} : 64'd0);
        mfull = 1'b0;
      end
      if (macc) begin
        h1 = ch1; h2 = ch2; mfull = 1'b1;
      end
      mcnt = mcnt + 8'd1;
    end
  end

  // Monitor: assembles each transmitted frame and compares it with the scoreboard
  logic [63:0] cur [2];
  logic        b0 [2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("cnt", {56'd0, cnt_o[d]}, {56'd0, mcnt});
      chk("bclk", {63'd0, bclk_o[d]}, {63'd0, mcnt[1]});
      chk("fs", {63'd0, fs_o[d]}, {63'd0, mcnt < 8'd4});
      chk("in_ready", {63'd0, rdy[d]}, {63'd0, !mfull});
      chk("underrun", {63'd0, ur_o[d]}, {63'd0, mu});
      chk("underrun_cnt", {48'd0, urc_o[d]}, 64'(mur));
      if (mrst) begin
        chk("rst_tdm_out", {63'd0, tdm_o[d]}, 64'd0);
        cur[d] = 64'd0;
        b0[d] = tdm_o[d];
      end else begin
        if (mcnt[1:0] == 2'd0) b0[d] = tdm_o[d];
        else chk("bit_stable", {63'd0, tdm_o[d]}, {63'd0, b0[d]});
        if (mcnt[1:0] == 2'd2) cur[d][63 - int'(mcnt[7:2])] = tdm_o[d];
      end
    end
    if (!mrst && mcnt == 8'd255) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
        chk("frame_repeat", cur[0], q0.pop_front());
        chk("frame_zero", cur[1], q1.pop_front());
      end
    end
  end

  task automatic wait_cnt(input logic [7:0] n);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (mcnt == n) return;
    end
    chk("wait_cnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_one(input logic [15:0] a, input logic [15:0] b);
    ch1 = a; ch2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // basic frame
    wait_cnt(8'd10);
    send_one(16'hA5C3, 16'h0F81);
    repeat (2) wait_cnt(8'd0);
    // underrun: one pair then three empty loads
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wait_cnt(8'd10);
    send_one(16'h1234, 16'h5678);
    repeat (4) wait_cnt(8'd0);
    @(negedge clk);
    chk("ucnt_after_3", {48'd0, urc_o[0]}, 64'd3);
    chk("underrun_flag", {63'd0, ur_o[1]}, 64'd1);
    // backpressure with incrementing data
    d = 16'h0100;
    ch1 = d; ch2 = ~d; in_valid = 1'b1;
    for (int i = 0; i < 8 * 256; i++) begin
      @(posedge clk); #1;
      if (macc) begin d++; ch1 = d; ch2 = ~d; end
    end
    in_valid = 1'b0;
    repeat (2) wait_cnt(8'd0);
    // load-edge collision while empty
    wait_cnt(8'd255);
    send_one(16'hBEEF, 16'hC0DE);
    repeat (2) wait_cnt(8'd0);
    // reset mid-frame with a pending pair
    wait_cnt(8'd50);
    send_one(16'h7777, 16'h8888);
    wait_cnt(8'd100);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ucnt_after_rst", {48'd0, urc_o[0]}, 64'd0);
    wait_cnt(8'd200);
    chk("no_ur_before_load", {63'd0, ur_o[0]}, 64'd0);
    repeat (2) wait_cnt(8'd0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 99) < 3);
      ch1 = 16'($urandom); ch2 = 16'($urandom);
    end
    in_valid = 1'b0;
    wait_cnt(8'd0);
    wait_cnt(8'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
